// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - iterative restoring divider for RISC-V DIV/DIVU/REM/REMU
// Define RISCV_DIV_FAST_SPECIAL_EN to retire divide-by-zero and signed overflow in one cycle.
module riscv_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             div_zero_o
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic             r_is_rem;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_special;
   logic             r_dz;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_spec_res;
   logic [WIDTH-1:0] r_result;
   logic             r_valid;
   logic             r_div_zero;

   logic             w_signed;
   logic             w_sign_a;
   logic             w_sign_b;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_dz;
   logic             w_ovf;
   logic [WIDTH-1:0] w_spec_res;
   logic             w_accept;
   logic             w_fast;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_neg;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;
   logic [WIDTH-1:0] w_fix_res;

   assign w_signed   = ~op_i[0];
   assign w_sign_a   = w_signed & dividend_i[WIDTH-1];
   assign w_sign_b   = w_signed & divisor_i[WIDTH-1];
   assign w_abs_a    = w_sign_a ? -dividend_i : dividend_i;
   assign w_abs_b    = w_sign_b ? -divisor_i : divisor_i;
   assign w_dz       = (divisor_i == {WIDTH{1'b0}});
   assign w_ovf      = w_signed && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor_i);
   // Architectural results for the two corner cases, fixed at acceptance time.
   assign w_spec_res = w_dz ? (op_i[1] ? dividend_i : {WIDTH{1'b1}})
                            : (op_i[1] ? {WIDTH{1'b0}} : dividend_i);
   assign w_accept   = (r_state == IDLE) && start_i && !flush_i;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
   assign w_fast     = w_accept && (w_dz || w_ovf);
`else
   assign w_fast     = 1'b0;
`endif

   // The shifted partial remainder needs WIDTH+1 bits; the MSB of the difference is the borrow.
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_diff     = w_shift - {1'b0, r_div};
   assign w_neg      = w_diff[WIDTH];

   assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
   assign w_rem_fix  = r_sign_a ? -r_rem : r_rem;
   assign w_fix_res  = r_special ? r_spec_res : (r_is_rem ? w_rem_fix : w_quo_fix);

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (flush_i) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_accept && !w_fast) w_state_next = CALC;
            CALC:    if (r_cnt == CW'(1)) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_is_rem   <= 1'b0;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_special  <= 1'b0;
         r_dz       <= 1'b0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_div      <= '0;
         r_spec_res <= '0;
         r_result   <= '0;
         r_valid    <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_is_rem   <= op_i[1];
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_special  <= w_dz | w_ovf;
            r_dz       <= w_dz;
            r_spec_res <= w_spec_res;
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_div      <= w_abs_b;
            r_cnt      <= CW'(WIDTH);
            if (w_fast) begin
               r_result   <= w_spec_res;
               r_div_zero <= w_dz;
               r_valid    <= 1'b1;
            end
         end else if ((r_state == CALC) && !flush_i) begin
            r_rem <= w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_neg};
            r_cnt <= r_cnt - CW'(1);
         end else if ((r_state == FIX) && !flush_i) begin
            r_result   <= w_fix_res;
            r_div_zero <= r_dz;
            r_valid    <= 1'b1;
         end
      end
   end

   assign busy_o     = (r_state != IDLE);
   assign valid_o    = r_valid;
   assign result_o   = r_result;
   assign div_zero_o = r_div_zero;

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb/tb_riscv_div_unit.sv - randomized self-checking bench for riscv_div_unit
// Honours RISCV_DIV_FAST_SPECIAL_EN when computing expected latency.
module tb_riscv_div_unit;
   localparam int WIDTH = 32;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic        div_zero_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   riscv_div_unit #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .flush_i    (flush_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o),
      .div_zero_o (div_zero_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M-extension semantics via native signed/unsigned arithmetic.
   function automatic logic [32:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        r;
      sa = a;
      sb = b;
      if (b == 32'h0) return {1'b1, op[1] ? a : 32'hFFFF_FFFF};
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, op[1] ? 32'h0 : a};
      case (op)
         2'b00:   r = sa / sb;
         2'b01:   r = a / b;
         2'b10:   r = sa % sb;
         default: r = a % b;
      endcase
      return {1'b0, r};
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bit special;
      special = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      return (FAST && special) ? 1 : WIDTH + 2;
   endfunction

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit sync);
      logic [32:0] exp;
      int          lat;
      int          exp_lat;
      logic        busy_e0;
      exp     = ref_div(op, a, b);
      exp_lat = ref_lat(op, a, b);
      if (sync) @(negedge clk);
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      @(posedge clk);
      #1;
      start_i    = 1'b0;
      op_i       = 2'($urandom_range(0, 3));
      dividend_i = $urandom;
      divisor_i  = $urandom;
      busy_e0    = busy_o;
      lat        = 1;
      while (!valid_o && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_after_start"}, 64'(busy_e0), 64'(exp_lat != 1));
      check({tag, " busy_at_valid"}, 64'(busy_o), 64'(0));
      check({tag, " result"}, 64'(result_o), 64'(exp[31:0]));
      check({tag, " div_zero"}, 64'(div_zero_o), 64'(exp[32]));
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] prev_res;
      logic        prev_dz;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [32:0] rexp;
      int          lat;
      int          vcount;

      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(busy_o), 64'(0));
      check("reset valid", 64'(valid_o), 64'(0));
      check("reset result", 64'(result_o), 64'(0));
      check("reset div_zero", 64'(div_zero_o), 64'(0));
      rst_i = 1'b0;

      run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b1);
      run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 1'b1);
      run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op("div by zero", 2'b00, 32'h1234, 32'h0, 1'b1);
      run_op("remu by zero", 2'b11, 32'h1234, 32'h0, 1'b1);
      run_op("div neg by zero", 2'b00, 32'hFFFF_FF00, 32'h0, 1'b1);
      run_op("b2b divu", 2'b01, 32'hFFFF_FFFF, 32'd3, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'h0;
            1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2, 3, 4: rb = 32'($urandom_range(1, 15));
            5:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run_op("random", rop, ra, rb, (i % 2) == 0);
         if ((i % 2) == 1) begin
            rexp = ref_div(rop, ra, rb);
            @(posedge clk);
            #1;
            check("valid pulse width", 64'(valid_o), 64'(0));
            check("result held", 64'(result_o), 64'(rexp[31:0]));
            check("div_zero held", 64'(div_zero_o), 64'(rexp[32]));
         end
      end

      run_op("divu 1000/10 pre", 2'b01, 32'd1000, 32'd10, 1'b1);
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd10;
      @(posedge clk);
      #1;
      op_i = 2'b00; dividend_i = 32'hDEAD; divisor_i = 32'h0;
      lat = 1;
      while (!valid_o && lat < 200) begin
         start_i = (lat >= 3 && lat <= 8);
         @(posedge clk);
         #1;
         lat++;
      end
      start_i = 1'b0;
      check("ignore start latency", 64'(lat), 64'(WIDTH + 2));
      check("ignore start result", 64'(result_o), 64'(100));
      check("ignore start div_zero", 64'(div_zero_o), 64'(0));

      prev_res = result_o;
      prev_dz  = div_zero_o;
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      check("flush busy low", 64'(busy_o), 64'(0));
      vcount = 0;
      for (int k = 0; k < 40; k++) begin
         vcount += int'(valid_o);
         @(posedge clk);
         #1;
      end
      check("flush no valid", 64'(vcount), 64'(0));
      check("flush result kept", 64'(result_o), 64'(prev_res));
      check("flush div_zero kept", 64'(div_zero_o), 64'(prev_dz));
      run_op("divu 9/3 after flush", 2'b01, 32'd9, 32'd3, 1'b1);

      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; dividend_i = 32'h55; divisor_i = 32'h0;
      @(posedge clk);
      #1;
      start_i = 1'b0; flush_i = 1'b0;
      vcount = 0;
      for (int k = 0; k < 40; k++) begin
         vcount += int'(valid_o) + int'(busy_o);
         @(posedge clk);
         #1;
      end
      check("flush beats start", 64'(vcount), 64'(0));
      check("flush beats start result", 64'(result_o), 64'(3));

      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd10;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_i = 1'b1;
      #1;
      check("async reset busy", 64'(busy_o), 64'(0));
      check("async reset valid", 64'(valid_o), 64'(0));
      check("async reset result", 64'(result_o), 64'(0));
      check("async reset div_zero", 64'(div_zero_o), 64'(0));
      @(posedge clk);
      #1;
      check("reset held busy", 64'(busy_o), 64'(0));
      rst_i = 1'b0;
      run_op("first after reset", 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1);
      run_op("b2b rem", 2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
